// File: rtl/risc_dof_hazard_ctrl.sv
// rtl/risc_dof_hazard_ctrl.sv - DOF-stage hazard scoreboard, stall and branch-flush sequencer
module risc_dof_hazard_ctrl #(
    parameter int PIPE_DEPTH   = 2,
    parameter int BRANCH_FLUSH = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dof_valid,
    input  logic [4:0]       dof_aa,
    input  logic [4:0]       dof_ba,
    input  logic [4:0]       dof_da,
    input  logic             dof_rw,
    input  logic             dof_use_a,
    input  logic             dof_use_b,
    input  logic             ex_branch_taken,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush_dof,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] hazard_count
);

    localparam int FC_W = (BRANCH_FLUSH > 2) ? $clog2(BRANCH_FLUSH) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(BRANCH_FLUSH - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t                     state, state_nxt;
    logic [FC_W-1:0]            fcnt, fcnt_nxt;
    logic [PIPE_DEPTH-1:0]      sb_v;
    logic [PIPE_DEPTH-1:0][4:0] sb_da;

    logic match_a, match_b, hazard, flush_raw, issue;

    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_v[i] && (sb_da[i] == dof_aa)) match_a = 1'b1;
            if (sb_v[i] && (sb_da[i] == dof_ba)) match_b = 1'b1;
        end
    end

    // R0 is hardwired zero, so it can never carry a dependency.
    assign hazard = dof_valid &
                    ((dof_use_a & (dof_aa != 5'd0) & match_a) |
                     (dof_use_b & (dof_ba != 5'd0) & match_b));

    assign flush_raw  = (state == ST_FLUSH) | ex_branch_taken;
    assign flush_dof  = reset & flush_raw;
    assign stall_if   = reset & hazard & ~flush_raw;
    assign bubble_ex  = ~reset | stall_if | flush_dof;
    assign ctrl_state = reset ? state : ST_RUN;
    assign issue      = dof_valid & ~stall_if & ~flush_dof;

    // fcnt holds the FLUSH-state cycles still to come after the branch cycle itself.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (ex_branch_taken) begin
            if (BRANCH_FLUSH > 1) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = FLUSH_LOAD;
            end else begin
                state_nxt = ST_RUN;
                fcnt_nxt  = '0;
            end
        end else begin
            case (state)
                ST_RUN:   if (hazard) state_nxt = ST_STALL;
                ST_STALL: if (!hazard) state_nxt = ST_RUN;
                ST_FLUSH: begin
                    if (fcnt <= FC_W'(1)) begin
                        state_nxt = ST_RUN;
                        fcnt_nxt  = '0;
                    end else begin
                        fcnt_nxt = fcnt - FC_W'(1);
                    end
                end
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_RUN;
            fcnt         <= '0;
            sb_v         <= '0;
            sb_da        <= '0;
            hazard_count <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                sb_v[i]  <= sb_v[i-1];
                sb_da[i] <= sb_da[i-1];
            end
            sb_v[0]  <= issue & dof_rw & (dof_da != 5'd0);
            sb_da[0] <= dof_da;
            if (stall_if && (hazard_count != {CNT_W{1'b1}}))
                hazard_count <= hazard_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_risc_dof_hazard_ctrl.sv
// tb/tb_risc_dof_hazard_ctrl.sv - scoreboard bench for risc_dof_hazard_ctrl
module tb_risc_dof_hazard_ctrl;

    localparam int CNT_W = 3;

    // expected {stall_if, bubble_ex, flush_dof, ctrl_state}
    localparam logic [4:0] E_RUN    = 5'b00000;
    localparam logic [4:0] E_STALL0 = 5'b11000;
    localparam logic [4:0] E_STALL1 = 5'b11001;
    localparam logic [4:0] E_LEAVE  = 5'b00001;
    localparam logic [4:0] E_BR     = 5'b01100;
    localparam logic [4:0] E_BRST   = 5'b01101;
    localparam logic [4:0] E_FL     = 5'b01110;
    localparam logic [4:0] E_RST    = 5'b01000;

    typedef struct packed {
        logic       rn;
        logic       v;
        logic [4:0] aa;
        logic [4:0] ba;
        logic [4:0] da;
        logic       rw;
        logic       ua;
        logic       ub;
        logic       br;
        logic [4:0] e;
    } row_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             dof_valid, dof_rw, dof_use_a, dof_use_b, ex_branch_taken;
    logic [4:0]       dof_aa, dof_ba, dof_da;
    logic             stall_if, bubble_ex, flush_dof;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] hazard_count;

    logic [4:0] exp_q[$];
    logic [4:0] got, want;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    risc_dof_hazard_ctrl #(.PIPE_DEPTH(2), .BRANCH_FLUSH(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba),
        .dof_da(dof_da), .dof_rw(dof_rw), .dof_use_a(dof_use_a), .dof_use_b(dof_use_b),
        .ex_branch_taken(ex_branch_taken), .stall_if(stall_if), .bubble_ex(bubble_ex),
        .flush_dof(flush_dof), .ctrl_state(ctrl_state), .hazard_count(hazard_count)
    );

    function automatic row_t r(input logic rn, input logic v, input logic [4:0] aa,
                               input logic [4:0] ba, input logic [4:0] da, input logic rw,
                               input logic ua, input logic ub, input logic br,
                               input logic [4:0] e);
        r = '{rn: rn, v: v, aa: aa, ba: ba, da: da, rw: rw, ua: ua, ub: ub, br: br, e: e};
    endfunction

    // Drives one DOF cycle at the falling edge and records its expected outputs.
    task automatic drive_row(input row_t x);
        @(negedge clk);
        reset = x.rn; dof_valid = x.v; dof_aa = x.aa; dof_ba = x.ba; dof_da = x.da;
        dof_rw = x.rw; dof_use_a = x.ua; dof_use_b = x.ub; ex_branch_taken = x.br;
        exp_q.push_back(x.e);
        #2;
    endtask

    task automatic test_reset();
        row_t rows[$];
        rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
        rows.push_back(r(0, 1, 3, 3, 3, 1, 1, 1, 1, E_RST));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL reset row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", hazard_count); end
    endtask

    task automatic test_raw_stall();
        row_t rows[$];
        rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 3, 0, 4, 1, 1, 0, 0, E_STALL0));
        rows.push_back(r(1, 1, 3, 0, 4, 1, 1, 0, 0, E_STALL1));
        rows.push_back(r(1, 1, 3, 0, 4, 1, 1, 0, 0, E_LEAVE));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL raw_stall row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd2) begin n_fail++; $display("FAIL raw_count: got %0d expected 2", hazard_count); end
    endtask

    task automatic test_gap();
        row_t rows[$];
        rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 5, 0, 0, 0, 1, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_STALL0));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_LEAVE));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL gap row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd3) begin n_fail++; $display("FAIL gap_count: got %0d expected 3", hazard_count); end
    endtask

    task automatic test_r0_and_operand_use();
        row_t rows[$];
        rows.push_back(r(1, 1, 0, 0, 0, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 0, 0, 5, 0, 1, 1, 0, E_RUN));
        rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 7, 3, 0, 0, 1, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 3, 3, 0, 0, 1, 1, 0, E_RUN));
        rows.push_back(r(1, 1, 0, 0, 6, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 0, 6, 0, 0, 0, 1, 0, E_STALL0));
        rows.push_back(r(1, 1, 0, 6, 0, 0, 0, 1, 0, E_STALL1));
        rows.push_back(r(1, 1, 0, 6, 0, 0, 0, 1, 0, E_LEAVE));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL r0_use row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd5) begin n_fail++; $display("FAIL r0_use_count: got %0d expected 5", hazard_count); end
    endtask

    task automatic test_branch_flush();
        row_t rows[$];
        rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 1, E_BR));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_FL));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 0, 0, 9, 1, 0, 0, 1, E_BR));
        rows.push_back(r(1, 1, 0, 0, 9, 1, 0, 0, 1, E_FL));
        rows.push_back(r(1, 1, 0, 0, 9, 1, 0, 0, 0, E_FL));
        rows.push_back(r(1, 1, 9, 0, 0, 0, 1, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_STALL0));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 1, E_BRST));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_FL));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL branch row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd6) begin n_fail++; $display("FAIL branch_count: got %0d expected 6", hazard_count); end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_STALL0));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_STALL1));
        rows.push_back(r(0, 1, 3, 0, 0, 0, 1, 0, 0, E_RST));
        rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_RUN));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 1, E_BR));
        rows.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL reset_mid row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd0) begin n_fail++; $display("FAIL reset_mid_count: got %0d expected 0", hazard_count); end
    endtask

    task automatic test_saturate();
        row_t rows[$];
        for (int k = 0; k < 4; k++) begin
            rows.push_back(r(1, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN));
            rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_STALL0));
            rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_STALL1));
            rows.push_back(r(1, 1, 3, 0, 0, 0, 1, 0, 0, E_LEAVE));
        end
        rows.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            got = {stall_if, bubble_ex, flush_dof, ctrl_state}; want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin n_fail++; $display("FAIL saturate row %0d: got %b expected %b", i, got, want); end
        end
        n_tests++;
        if (hazard_count !== 3'd7) begin n_fail++; $display("FAIL saturate_count: got %0d expected 7", hazard_count); end
    endtask

    initial begin
        reset = 1'b0; dof_valid = 1'b0; dof_aa = '0; dof_ba = '0; dof_da = '0;
        dof_rw = 1'b0; dof_use_a = 1'b0; dof_use_b = 1'b0; ex_branch_taken = 1'b0;
        test_reset();
        test_raw_stall();
        test_gap();
        test_r0_and_operand_use();
        test_branch_flush();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
